tx_uart_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter; the next-generation serial TX for the UART datapath. It serialises one DATA_BITS-wide word per frame, LSB first, paced by the shared baud-tick generator (N_TICKS ticks per bit). It adds an optional even/odd parity bit, a selectable one or two stop bits, a busy flag and a defined start/done handshake. Frame configuration is latched per frame, so it can change between frames without glitching the line.

---
 rtl/tx_uart_cfg.sv | 161 ++++++++++++++++
 tb/tb_tx_uart_cfg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart_cfg.sv
// Runtime-configurable UART transmitter: LSB-first data, optional even/odd parity, one or two stop bits.
// Frame configuration is captured when a request is accepted, so the inputs may change freely mid-frame.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line high, waiting for i_tx_start; ticks ignored
//   S_START  | start bit (line low) for N_TICKS ticks
//   S_DATA   | DATA_BITS data bits, LSB first, N_TICKS ticks each
//   S_PARITY | parity bit from the latched word, N_TICKS ticks
//   S_STOP   | line high for N_TICKS or 2*N_TICKS ticks, then done pulse
module tx_uart_cfg #(
   parameter int DATA_BITS = 8,
   parameter int N_TICKS   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_ticks,
   input  logic                 i_tx_start,
   input  logic [DATA_BITS-1:0] i_data_in,
   input  logic [1:0]           i_parity_mode,
   input  logic                 i_stop_2,
   output logic                 o_busy,
   output logic                 o_tx_done,
   output logic                 o_data_out
);

   localparam int TW = $clog2(N_TICKS);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW:0]   C_BIT_LAST   = (TW+1)'(N_TICKS - 1);
   localparam logic [TW:0]   C_STOP2_LAST = (TW+1)'(2 * N_TICKS - 1);
   localparam logic [BW-1:0] C_BITS_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state;
   logic [TW:0]          r_tick_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic [1:0]           r_pmode;
   logic                 r_stop2;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_line;

   logic                 w_bit_end;
   logic                 w_par_en;
   logic                 w_par_bit;
   logic [TW:0]          w_stop_last;

   // Down-counter reloaded at every bit start; the bit ends on the tick that finds it at zero.
   assign w_bit_end   = i_ticks && (r_tick_cnt == '0);
   assign w_par_en    = (r_pmode == 2'd1) || (r_pmode == 2'd2);
   assign w_par_bit   = (^r_data) ^ (r_pmode == 2'd2);
   assign w_stop_last = r_stop2 ? C_STOP2_LAST : C_BIT_LAST;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_pmode    <= 2'd0;
         r_stop2    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_line     <= 1'b1;
      end else begin
         r_done <= 1'b0;

         if (r_state != S_IDLE && i_ticks && r_tick_cnt != '0) begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_tick_cnt <= '0;
               r_line     <= 1'b1;
               if (i_tx_start) begin
                  r_shift    <= i_data_in;
                  r_data     <= i_data_in;
                  r_pmode    <= i_parity_mode;
                  r_stop2    <= i_stop_2;
                  r_tick_cnt <= C_BIT_LAST;
                  r_bit_cnt  <= '0;
                  r_line     <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_line     <= r_shift[0];
                  r_tick_cnt <= C_BIT_LAST;
                  r_bit_cnt  <= '0;
                  r_state    <= S_DATA;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == C_BITS_LAST) begin
                     if (w_par_en) begin
                        r_line     <= w_par_bit;
                        r_tick_cnt <= C_BIT_LAST;
                        r_state    <= S_PARITY;
                     end else begin
                        r_line     <= 1'b1;
                        r_tick_cnt <= w_stop_last;
                        r_state    <= S_STOP;
                     end
                  end else begin
                     r_shift    <= r_shift >> 1;
                     r_line     <= r_shift[1];
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                     r_tick_cnt <= C_BIT_LAST;
                  end
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_line     <= 1'b1;
                  r_tick_cnt <= w_stop_last;
                  r_state    <= S_STOP;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_line     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_tick_cnt <= '0;
                  r_state    <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_line  <= 1'b1;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_tx_done  = r_done;
   assign o_data_out = r_line;

endmodule

// File: tb/tb_tx_uart_cfg.sv
// Bench for tx_uart_cfg: a frame-level model (list of line bits, each N_TICKS ticks long)
// predicts line, busy and done every cycle under directed and randomized stimulus.
module tb_tx_uart_cfg;

   localparam int DB = 8;
   localparam int NT = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          tick;
   logic          start;
   logic [DB-1:0] data;
   logic [1:0]    pmode;
   logic          stop2;
   logic          busy;
   logic          done;
   logic          line;

   always #5 clk = ~clk;

   tx_uart_cfg #(.DATA_BITS(DB), .N_TICKS(NT)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_ticks       (tick),
      .i_tx_start    (start),
      .i_data_in     (data),
      .i_parity_mode (pmode),
      .i_stop_2      (stop2),
      .o_busy        (busy),
      .o_tx_done     (done),
      .o_data_out    (line)
   );

   int checks   = 0;
   int failures = 0;

   // frame model
   bit m_active = 1'b0;
   bit m_done   = 1'b0;
   int m_cnt    = 0;
   bit m_bits[$];

   int period   = 1;
   int ph       = 0;
   int busy_cyc = 0;
   int done_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic void build_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2);
      m_bits.delete();
      m_bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) m_bits.push_back(d[i]);
      if (pm == 2'd1) m_bits.push_back(^d);
      if (pm == 2'd2) m_bits.push_back(~^d);
      m_bits.push_back(1'b1);
      if (s2) m_bits.push_back(1'b1);
   endfunction

   task automatic step();
      tick = (ph == 0);
      @(posedge clk);
      if (rst) begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end else if (!m_active) begin
         m_done = 1'b0;
         if (start) begin
            build_frame(data, pmode, stop2);
            m_active = 1'b1;
            m_cnt    = 0;
         end
      end else begin
         m_done = 1'b0;
         if (tick) m_cnt++;
         if (m_cnt == m_bits.size() * NT) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      ph = (ph + 1) % period;
      #1;
      check_val("line", line, m_active ? m_bits[m_cnt / NT] : 1'b1);
      check_val("busy", busy, m_active);
      check_val("done", done, m_done);
      if (busy) busy_cyc++;
      if (done) done_cnt++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while (m_active && n < max) begin
         step();
         n++;
      end
      check_val("frame_timeout", m_active, 0);
   endtask

   task automatic send(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2);
      data  = d;
      pmode = pm;
      stop2 = s2;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int d0;
      rst   = 1'b1;
      start = 1'b0;
      data  = '0;
      pmode = 2'd0;
      stop2 = 1'b0;
      tick  = 1'b0;
      steps(3);
      rst = 1'b0;
      steps(3);

      // 0xA5, no parity, 1 stop, tick every 4 clocks aligned to the accept edge
      period = 4;
      ph = 1;
      while (ph != 0) step();
      busy_cyc = 0;
      done_cnt = 0;
      send(8'hA5, 2'd0, 1'b0);
      run_idle(2000);
      steps(4);
      check_val("a5_busy_cycles", busy_cyc, 640);
      check_val("a5_done_count", done_cnt, 1);

      // parity on 0x07, tick every clock
      period = 1;
      ph = 0;
      busy_cyc = 0;
      send(8'h07, 2'd1, 1'b0);
      steps(152);
      check_val("par_even_bit", line, 1);
      run_idle(500);
      check_val("par_even_len", busy_cyc, 176);
      busy_cyc = 0;
      send(8'h07, 2'd2, 1'b0);
      steps(152);
      check_val("par_odd_bit", line, 0);
      run_idle(500);
      check_val("par_odd_len", busy_cyc, 176);

      // 0xFF with two stop bits
      busy_cyc = 0;
      send(8'hFF, 2'd0, 1'b1);
      run_idle(500);
      check_val("stop2_len", busy_cyc, 176);
      steps(2);

      // start pulsed mid-DATA is ignored
      done_cnt = 0;
      send(8'h55, 2'd0, 1'b0);
      steps(40);
      data  = 8'h3C;
      start = 1'b1;
      step();
      start = 1'b0;
      run_idle(500);
      steps(20);
      check_val("busy_ignore_done", done_cnt, 1);

      // start held high: back-to-back frames
      start = 1'b1;
      for (int f = 0; f < 3; f++) begin
         data  = DB'($urandom);
         pmode = 2'($urandom_range(0, 3));
         stop2 = 1'($urandom_range(0, 1));
         step();
         run_idle(1000);
      end
      start = 1'b0;
      steps(3);

      // reset during data bit 3
      done_cnt = 0;
      send(8'hA5, 2'd1, 1'b0);
      steps(16 + 16 * 3 + 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_val("rst_mid_line", line, 1);
      check_val("rst_mid_busy", busy, 0);
      steps(3);
      check_val("rst_mid_no_done", done_cnt, 0);
      send(8'h3C, 2'd1, 1'b1);
      run_idle(500);
      check_val("after_rst_done", done_cnt, 1);

      // parity mode changed mid-frame, next frame odd
      send(8'h5A, 2'd1, 1'b0);
      steps(50);
      pmode = 2'd2;
      run_idle(500);
      send(8'h5A, 2'd2, 1'b0);
      run_idle(500);

      // randomized frames with spurious starts and config changes mid-frame
      for (int f = 0; f < 25; f++) begin
         period = $urandom_range(1, 3);
         d0 = $urandom_range(0, 5);
         steps(d0);
         send(DB'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         while (m_active) begin
            start = ($urandom_range(0, 30) == 0);
            data  = DB'($urandom);
            if ($urandom_range(0, 20) == 0) pmode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 20) == 0) stop2 = 1'($urandom_range(0, 1));
            step();
            if (busy_cyc > 90000) break;
         end
         start = 1'b0;
         check_val("rand_timeout", m_active, 0);
      end
      steps(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
